// File: rtl/dcache_pass_fifo_if.sv
// AXI3 read (AR/R) and write (AW/W/B) channel bundles used by the uncached D-side path.
// BUS_WIDTH is the data bus width in bytes.
interface axi3_rd_if #(
  parameter int unsigned BUS_WIDTH = 4
);
  localparam int unsigned DW = BUS_WIDTH * 8;

  logic [3:0]    arid;
  logic [31:0]   araddr;
  logic [3:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic [1:0]    arlock;
  logic [3:0]    arcache;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;
  logic [3:0]    rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

interface axi3_wr_if #(
  parameter int unsigned BUS_WIDTH = 4
);
  localparam int unsigned DW = BUS_WIDTH * 8;

  logic [3:0]           awid;
  logic [31:0]          awaddr;
  logic [3:0]           awlen;
  logic [2:0]           awsize;
  logic [1:0]           awburst;
  logic [1:0]           awlock;
  logic [3:0]           awcache;
  logic [2:0]           awprot;
  logic                 awvalid;
  logic                 awready;
  logic [3:0]           wid;
  logic [DW-1:0]        wdata;
  logic [BUS_WIDTH-1:0] wstrb;
  logic                 wlast;
  logic                 wvalid;
  logic                 wready;
  logic [3:0]           bid;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/dcache_pass_fifo.sv
// Uncached D-side pass-through queue: in-order FIFO of load/store lines, each issued as one
// single-beat AXI3 access. Define DCACHE_PASS_RLINE_REG_EN to register the rline output.
module dcache_pass_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ARID       = 2,
  parameter int unsigned AWID       = 2,
  parameter int unsigned DATA_DEPTH = 8,
  localparam int unsigned LINE_W    = 1 + DATA_WIDTH / 8 + 32 - $clog2(DATA_WIDTH / 8) + DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] pline,
  input  logic              push,
  output logic              full,
  output logic [LINE_W-1:0] rline,
  axi3_rd_if.master         axi3_rd,
  axi3_wr_if.master         axi3_wr
);

  localparam int unsigned BE_W    = DATA_WIDTH / 8;
  localparam int unsigned OFF_W   = $clog2(BE_W);
  localparam int unsigned LABEL_W = 32 - OFF_W;
  localparam int unsigned PTR_W   = $clog2(DATA_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;

  typedef struct packed {
    logic                  ls_type;
    logic [BE_W-1:0]       be;
    logic [LABEL_W-1:0]    label;
    logic [DATA_WIDTH-1:0] data;
  } line_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B
  } state_t;

  line_t            fifo_mem [DATA_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  state_t           state_q;
  state_t           state_nxt;
  line_t            head;
  logic             empty_c;
  logic             push_ok_c;
  logic             pop_c;
  logic             arvalid_c;
  logic             rready_c;
  logic             awvalid_c;
  logic             wvalid_c;
  logic             bready_c;
  logic [LINE_W-1:0] rline_c;
  logic             unused_c;

  assign head      = fifo_mem[rd_ptr];
  assign empty_c   = (count == '0);
  assign full      = (count == CNT_W'(DATA_DEPTH));
  assign push_ok_c = push && !full;

  // Entry storage carries no reset; only the pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      fifo_mem[wr_ptr] <= line_t'(pline);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
      if (push_ok_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push_ok_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head sequencer: one outstanding access; the entry retires only on its R or B handshake.
  always_comb begin
    state_nxt = state_q;
    arvalid_c = 1'b0;
    rready_c  = 1'b0;
    awvalid_c = 1'b0;
    wvalid_c  = 1'b0;
    bready_c  = 1'b0;
    pop_c     = 1'b0;
    rline_c   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty_c) begin
          state_nxt = head.ls_type ? ST_AR : ST_AW;
        end
      end
      ST_AR: begin
        arvalid_c = 1'b1;
        if (axi3_rd.arready) begin
          state_nxt = ST_R;
        end
      end
      ST_R: begin
        rready_c = 1'b1;
        if (axi3_rd.rvalid) begin
          pop_c     = 1'b1;
          rline_c   = {1'b1, head.be, head.label, DATA_WIDTH'(axi3_rd.rdata)};
          state_nxt = ST_IDLE;
        end
      end
      ST_AW: begin
        awvalid_c = 1'b1;
        if (axi3_wr.awready) begin
          state_nxt = ST_W;
        end
      end
      ST_W: begin
        wvalid_c = 1'b1;
        if (axi3_wr.wready) begin
          state_nxt = ST_B;
        end
      end
      ST_B: begin
        bready_c = 1'b1;
        if (axi3_wr.bvalid) begin
          pop_c     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef DCACHE_PASS_RLINE_REG_EN
  logic [LINE_W-1:0] rline_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rline_q <= '0;
    end else begin
      rline_q <= rline_c;
    end
  end

  assign rline = rline_q;
`else
  assign rline = rline_c;
`endif

  // Read channel: single-beat INCR word access at the head's label.
  assign axi3_rd.arid    = 4'(ARID);
  assign axi3_rd.araddr  = {head.label, {OFF_W{1'b0}}};
  assign axi3_rd.arlen   = 4'd0;
  assign axi3_rd.arsize  = 3'(OFF_W);
  assign axi3_rd.arburst = 2'b01;
  assign axi3_rd.arlock  = 2'b00;
  assign axi3_rd.arcache = 4'd0;
  assign axi3_rd.arprot  = 3'd0;
  assign axi3_rd.arvalid = arvalid_c;
  assign axi3_rd.rready  = rready_c;

  // Write channel: same attributes, one beat carrying the head's data and byte enables.
  assign axi3_wr.awid    = 4'(AWID);
  assign axi3_wr.awaddr  = {head.label, {OFF_W{1'b0}}};
  assign axi3_wr.awlen   = 4'd0;
  assign axi3_wr.awsize  = 3'(OFF_W);
  assign axi3_wr.awburst = 2'b01;
  assign axi3_wr.awlock  = 2'b00;
  assign axi3_wr.awcache = 4'd0;
  assign axi3_wr.awprot  = 3'd0;
  assign axi3_wr.awvalid = awvalid_c;
  assign axi3_wr.wid     = 4'(AWID);
  assign axi3_wr.wdata   = head.data;
  assign axi3_wr.wstrb   = head.be;
  assign axi3_wr.wlast   = wvalid_c;
  assign axi3_wr.wvalid  = wvalid_c;
  assign axi3_wr.bready  = bready_c;

  // Response IDs, codes and rlast carry no information for single-beat in-order traffic.
  assign unused_c = ^{axi3_rd.rid, axi3_rd.rresp, axi3_rd.rlast, axi3_wr.bid, axi3_wr.bresp};

endmodule

// File: tb/tb_dcache_pass_fifo.sv
// Directed bench for dcache_pass_fifo with a word-addressed AXI3 memory slave.
module tb_dcache_pass_fifo;
  localparam int unsigned LW = 67;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [LW-1:0] pline = '0;
  logic          push = 1'b0;
  logic          full;
  logic [LW-1:0] rline;

  axi3_rd_if #(.BUS_WIDTH(4)) rd_bus ();
  axi3_wr_if #(.BUS_WIDTH(4)) wr_bus ();

  dcache_pass_fifo dut (
    .clk     (clk),
    .rst     (rst),
    .pline   (pline),
    .push    (push),
    .full    (full),
    .rline   (rline),
    .axi3_rd (rd_bus),
    .axi3_wr (wr_bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int stab_bad  = 0;
  int order_bad = 0;

  // Slave controls
  logic hold_ar   = 1'b0;
  logic hold_r    = 1'b0;
  logic rand_mode = 1'b0;

  logic [31:0] mem [256];
  logic        mem_init = 1'b0;
  logic        ar_gate, aw_gate, w_gate;
  logic        r_pending, b_pending, wr_busy;
  logic [1:0]  r_delay, b_delay;
  logic [31:0] r_data;
  logic [31:0] aw_addr;
  logic [31:0] last_araddr, last_awaddr, last_wdata;
  logic [3:0]  last_wstrb;
  logic [21:0] last_ar_attr, last_aw_attr;
  logic [4:0]  last_w_attr;

  assign rd_bus.arready = ar_gate && !hold_ar;
  assign rd_bus.rvalid  = r_pending && (r_delay == 2'd0) && !hold_r;
  assign rd_bus.rdata   = r_data;
  assign rd_bus.rid     = 4'd2;
  assign rd_bus.rresp   = 2'b00;
  assign rd_bus.rlast   = 1'b1;
  assign wr_bus.awready = aw_gate;
  assign wr_bus.wready  = w_gate;
  assign wr_bus.bvalid  = b_pending && (b_delay == 2'd0);
  assign wr_bus.bid     = 4'd2;
  assign wr_bus.bresp   = 2'b10;

  // Memory slave: mem[i] = i at first reset; optional random ready gaps and response delays.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= 1'b0;
      b_pending <= 1'b0;
      wr_busy   <= 1'b0;
      r_delay   <= 2'd0;
      b_delay   <= 2'd0;
      ar_gate   <= 1'b1;
      aw_gate   <= 1'b1;
      w_gate    <= 1'b1;
      if (!mem_init) begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
        mem_init <= 1'b1;
      end
    end else begin
      ar_gate <= rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      aw_gate <= rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      w_gate  <= rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_bus.arvalid && rd_bus.arready) begin
        r_pending    <= 1'b1;
        r_delay      <= rand_mode ? 2'($urandom_range(0, 2)) : 2'd0;
        r_data       <= mem[rd_bus.araddr[9:2]];
        last_araddr  <= rd_bus.araddr;
        last_ar_attr <= {rd_bus.arlen, rd_bus.arsize, rd_bus.arburst, rd_bus.arlock,
                         rd_bus.arcache, rd_bus.arprot, rd_bus.arid};
      end else if (r_pending && r_delay != 2'd0) begin
        r_delay <= r_delay - 2'd1;
      end
      if (rd_bus.rvalid && rd_bus.rready) r_pending <= 1'b0;
      if (wr_bus.awvalid && wr_bus.awready) begin
        aw_addr      <= wr_bus.awaddr;
        last_awaddr  <= wr_bus.awaddr;
        wr_busy      <= 1'b1;
        last_aw_attr <= {wr_bus.awlen, wr_bus.awsize, wr_bus.awburst, wr_bus.awlock,
                         wr_bus.awcache, wr_bus.awprot, wr_bus.awid};
      end
      if (wr_bus.wvalid && wr_bus.wready) begin
        for (int b = 0; b < 4; b++)
          if (wr_bus.wstrb[b]) mem[aw_addr[9:2]][8*b +: 8] <= wr_bus.wdata[8*b +: 8];
        last_wstrb  <= wr_bus.wstrb;
        last_wdata  <= wr_bus.wdata;
        last_w_attr <= {wr_bus.wid, wr_bus.wlast};
        b_pending   <= 1'b1;
        b_delay     <= rand_mode ? 2'($urandom_range(0, 2)) : 2'd0;
      end else if (b_pending && b_delay != 2'd0) begin
        b_delay <= b_delay - 2'd1;
      end
      if (wr_bus.bvalid && wr_bus.bready) begin
        b_pending <= 1'b0;
        wr_busy   <= 1'b0;
      end
    end
  end

  // Protocol watch: valids held with stable payload until handshake; no read while a write is open.
  logic        ar_wait, aw_wait, w_wait;
  logic [31:0] ar_hold, aw_hold;
  logic [35:0] w_hold;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ar_wait <= 1'b0;
      aw_wait <= 1'b0;
      w_wait  <= 1'b0;
    end else begin
      if (ar_wait && !(rd_bus.arvalid && rd_bus.araddr == ar_hold)) begin
        stab_bad <= stab_bad + 1;
        $error("FAIL ar_stable: arvalid=%0b araddr=%h held=%h", rd_bus.arvalid, rd_bus.araddr, ar_hold);
      end
      if (aw_wait && !(wr_bus.awvalid && wr_bus.awaddr == aw_hold)) begin
        stab_bad <= stab_bad + 1;
        $error("FAIL aw_stable: awvalid=%0b awaddr=%h held=%h", wr_bus.awvalid, wr_bus.awaddr, aw_hold);
      end
      if (w_wait && !(wr_bus.wvalid && {wr_bus.wstrb, wr_bus.wdata} == w_hold)) begin
        stab_bad <= stab_bad + 1;
        $error("FAIL w_stable: wvalid=%0b w=%h held=%h", wr_bus.wvalid, {wr_bus.wstrb, wr_bus.wdata}, w_hold);
      end
      if (rd_bus.arvalid && wr_busy) begin
        order_bad <= order_bad + 1;
        $error("FAIL rd_after_wr: arvalid=1 while write open, want arvalid=0");
      end
      ar_wait <= rd_bus.arvalid && !rd_bus.arready;
      aw_wait <= wr_bus.awvalid && !wr_bus.awready;
      w_wait  <= wr_bus.wvalid && !wr_bus.wready;
      ar_hold <= rd_bus.araddr;
      aw_hold <= wr_bus.awaddr;
      w_hold  <= {wr_bus.wstrb, wr_bus.wdata};
    end
  end

  // Result collector
  logic [LW-1:0] got_q [$];
  always @(negedge clk) begin
    if (rline[LW-1]) got_q.push_back(rline);
  end

  function automatic logic [LW-1:0] mk(input logic t, input logic [3:0] be,
                                       input logic [29:0] lab, input logic [31:0] d);
    return {t, be, lab, d};
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_line(input logic [LW-1:0] l);
    pline = l;
    push  = 1'b1;
    @(negedge clk);
    push  = 1'b0;
  endtask

  task automatic wait_got(input int target, input int budget, output int cycles);
    cycles = 0;
    while (got_q.size() < target && cycles < budget) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    total++;
    assert (got_q.size() >= target)
    else begin
      bad++;
      $error("FAIL wait_got: got=%0d results exp=%0d", got_q.size(), target);
    end
  endtask

  logic [31:0]   model [256];
  logic [LW-1:0] exp_q [$];
  int            base, cyc, g, lat_exp;
  logic          hang;
  logic          is_ld;
  logic [3:0]    rbe;
  logic [29:0]   rlab;
  logic [31:0]   rdat;

  initial begin
`ifdef DCACHE_PASS_RLINE_REG_EN
    lat_exp = 3;
`else
    lat_exp = 2;
`endif
    for (int i = 0; i < 256; i++) model[i] = 32'(i);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_full", LW'(full), '0);
    check("rst_rline", rline, '0);
    check("rst_valids", LW'({rd_bus.arvalid, wr_bus.awvalid, wr_bus.wvalid, rd_bus.rready, wr_bus.bready}), '0);
    rst = 1'b1;
    @(negedge clk);

    // Single load
    base = got_q.size();
    push_line(mk(1'b1, 4'hf, 30'h10, 32'h0));
    wait_got(base + 1, 50, cyc);
    check("t1_load", got_q[base], mk(1'b1, 4'hf, 30'h10, 32'h10));
    check("t1_latency", LW'(cyc), LW'(lat_exp));
    check("t1_araddr", LW'(last_araddr), LW'(32'h40));
    check("t1_ar_attr", LW'(last_ar_attr), LW'({4'h0, 3'd2, 2'b01, 2'b00, 4'h0, 3'h0, 4'h2}));
    repeat (5) @(negedge clk);
    check("t1_count", LW'(got_q.size()), LW'(base + 1));

    // Store then load of the same word
    base = got_q.size();
    push_line(mk(1'b0, 4'h3, 30'h20, 32'hAABBCCDD));
    push_line(mk(1'b1, 4'hf, 30'h20, 32'h0));
    wait_got(base + 1, 60, cyc);
    check("t2_wstrb", LW'(last_wstrb), LW'(4'h3));
    check("t2_wdata", LW'(last_wdata), LW'(32'hAABBCCDD));
    check("t2_awaddr", LW'(last_awaddr), LW'(32'h80));
    check("t2_aw_attr", LW'(last_aw_attr), LW'({4'h0, 3'd2, 2'b01, 2'b00, 4'h0, 3'h0, 4'h2}));
    check("t2_w_attr", LW'(last_w_attr), LW'({4'h2, 1'b1}));
    check("t2_load", got_q[base], mk(1'b1, 4'hf, 30'h20, 32'h0000CCDD));
    repeat (5) @(negedge clk);
    check("t2_count", LW'(got_q.size()), LW'(base + 1));
    model[8'h20] = 32'h0000CCDD;

    // Nine back-to-back loads with arready held low
    base    = got_q.size();
    hold_ar = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      pline = mk(1'b1, 4'hf, 30'(8'h30 + i), 32'h0);
      push  = 1'b1;
      @(negedge clk);
      if (i == 6) check("t3_not_full_7", LW'(full), '0);
      if (i == 7) check("t3_full_8", LW'(full), LW'(1'b1));
    end
    push = 1'b0;
    check("t3_full_9", LW'(full), LW'(1'b1));
    check("t3_no_result", LW'(got_q.size()), LW'(base));
    hold_ar = 1'b0;
    wait_got(base + 8, 200, cyc);
    repeat (10) @(negedge clk);
    check("t3_count", LW'(got_q.size()), LW'(base + 8));
    for (int i = 0; i < 8; i++)
      check($sformatf("t3_load%0d", i), got_q[base + i], mk(1'b1, 4'hf, 30'(8'h30 + i), 32'(8'h30 + i)));
    check("t3_drained", LW'(full), '0);

    // Interleaved random loads/stores with a stalling slave
    base      = got_q.size();
    rand_mode = 1'b1;
    hang      = 1'b0;
    exp_q.delete();
    @(negedge clk);
    for (int n = 0; n < 200; n++) begin
      is_ld = 1'($urandom_range(0, 1));
      rlab  = 30'(8'h40 + $urandom_range(0, 7));
      rbe   = 4'($urandom_range(1, 15));
      rdat  = $urandom();
      g     = 0;
      while (full && g < 500) begin
        @(negedge clk);
        g++;
      end
      if (g >= 500) hang = 1'b1;
      push_line(mk(is_ld, rbe, rlab, rdat));
      if (is_ld) begin
        exp_q.push_back(mk(1'b1, rbe, rlab, model[rlab[7:0]]));
      end else begin
        for (int b = 0; b < 4; b++)
          if (rbe[b]) model[rlab[7:0]][8*b +: 8] = rdat[8*b +: 8];
      end
    end
    wait_got(base + exp_q.size(), 20000, cyc);
    repeat (20) @(negedge clk);
    check("t4_push_stall", LW'(hang), '0);
    check("t4_count", LW'(got_q.size()), LW'(base + exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("t4_load%0d", i), got_q[base + i], exp_q[i]);
    rand_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_stable", LW'(stab_bad), '0);
    check("t4_order", LW'(order_bad), '0);

    // Reset while a read response is pending
    hold_r = 1'b1;
    for (int i = 0; i < 8; i++) push_line(mk(1'b1, 4'hf, 30'(8'h50 + i), 32'h0));
    g = 0;
    while (!rd_bus.rready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("t5_in_r", LW'(rd_bus.rready), LW'(1'b1));
    check("t5_full_pre", LW'(full), LW'(1'b1));
    base = got_q.size();
    #2 rst = 1'b0;
    #1;
    check("t5_valids", LW'({rd_bus.arvalid, wr_bus.awvalid, wr_bus.wvalid, rd_bus.rready, wr_bus.bready}), '0);
    check("t5_full", LW'(full), '0);
    check("t5_rline", rline, '0);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b1;
    hold_r = 1'b0;
    check("t5_no_result", LW'(got_q.size()), LW'(base));
    push_line(mk(1'b1, 4'hf, 30'h11, 32'h0));
    wait_got(base + 1, 50, cyc);
    repeat (20) @(negedge clk);
    check("t5_count", LW'(got_q.size()), LW'(base + 1));
    check("t5_load", got_q[base], mk(1'b1, 4'hf, 30'h11, 32'h11));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
